// File: rtl/div_pkg.sv
// Shared types and constants for the RV32M iterative divider.
package div_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic [XLEN-1:0] neg2c(input logic [XLEN-1:0] x);
    return ~x + XLEN'(1);
  endfunction

endpackage

// File: rtl/div_if.sv
// Request/response bundle between the EX stage and the divider.
interface div_if;
  import div_pkg::*;

  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, op, a, b, input busy, done, result);
  modport slave  (input start, op, a, b, output busy, done, result);
endinterface

// File: rtl/div_step.sv
// One restoring radix-2 iteration on unsigned magnitudes (combinational).
module div_step
  import div_pkg::*;
(
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_nx,
  output logic [XLEN-1:0] quo_nx
);
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] trial;

  // With rem < divisor on entry, trial[XLEN] is exactly the borrow of the subtract.
  always_comb begin
    rem_sh = {rem, quo[XLEN-1]};
    trial  = rem_sh - {1'b0, divisor};
    if (trial[XLEN]) begin
      rem_nx = rem_sh[XLEN-1:0];
      quo_nx = {quo[XLEN-2:0], 1'b0};
    end else begin
      rem_nx = trial[XLEN-1:0];
      quo_nx = {quo[XLEN-2:0], 1'b1};
    end
  end
endmodule

// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU; 33 cycles start-to-done
// (1 cycle for b==0 / signed overflow when DIV_FASTPATH_EN is defined).
// Backpressure: start is ignored while busy; accepted again in the done cycle.
module div_unit
  import div_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic clk,
  input  logic rst,
  div_if.slave bus
);
  state_t          state;
  logic [XLEN-1:0] rem, quo, divisor, a_q, result_q;
  logic [XLEN-1:0] rem_nx, quo_nx;
  logic [CNT_W-1:0] cnt;
  logic [1:0]      op_q;
  logic            neg_q, neg_r, bz_q, ovf_q, busy_q, done_q;
  logic            is_signed, sa, sb, b_zero, ovf, fast;

  function automatic logic [XLEN-1:0] finalise(
    input logic [1:0]      op,
    input logic            bz,
    input logic            ov,
    input logic            nq,
    input logic            nr,
    input logic [XLEN-1:0] q,
    input logic [XLEN-1:0] r,
    input logic [XLEN-1:0] a_raw
  );
    logic [XLEN-1:0] qf, rf;
    qf = nq ? neg2c(q) : q;
    rf = nr ? neg2c(r) : r;
    if (bz) begin
      qf = '1;
      rf = a_raw;
    end else if (ov) begin
      qf = MIN_NEG;
      rf = '0;
    end
    return (op == OP_REM || op == OP_REMU) ? rf : qf;
  endfunction

  always_comb begin
    is_signed = (bus.op == OP_DIV) || (bus.op == OP_REM);
    sa        = is_signed & bus.a[XLEN-1];
    sb        = is_signed & bus.b[XLEN-1];
    b_zero    = (bus.b == '0);
    ovf       = is_signed && (bus.a == MIN_NEG) && (bus.b == '1);
  end

`ifdef DIV_FASTPATH_EN
  assign fast = b_zero | ovf;
`else
  assign fast = 1'b0;
`endif

  div_step u_step (
    .rem     (rem),
    .quo     (quo),
    .divisor (divisor),
    .rem_nx  (rem_nx),
    .quo_nx  (quo_nx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      divisor  <= '0;
      a_q      <= '0;
      op_q     <= OP_DIV;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      bz_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            op_q    <= bus.op;
            neg_q   <= sa ^ sb;
            neg_r   <= sa;
            a_q     <= bus.a;
            bz_q    <= b_zero;
            ovf_q   <= ovf;
            quo     <= sa ? neg2c(bus.a) : bus.a;
            divisor <= sb ? neg2c(bus.b) : bus.b;
            rem     <= '0;
            cnt     <= '0;
            if (fast) begin
              state    <= S_DONE;
              done_q   <= 1'b1;
              result_q <= finalise(bus.op, b_zero, ovf, 1'b0, 1'b0, '0, '0, bus.a);
            end else begin
              state  <= S_RUN;
              busy_q <= 1'b1;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(XLEN - 1)) begin
            state    <= S_DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= finalise(op_q, bz_q, ovf_q, neg_q, neg_r, quo_nx, rem_nx, a_q);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
endmodule
